// File: rtl/rf_pkg.sv
// Shared definitions for the register-transfer sequencer: command op codes,
// FSM state encoding, register file FunSel codes and index-to-enable mapping.
package rf_pkg;

  typedef enum logic [2:0] {
    OP_LOAD    = 3'b000,
    OP_MOVE    = 3'b001,
    OP_SWAP    = 3'b010,
    OP_INC     = 3'b011,
    OP_DEC     = 3'b100,
    OP_CLR     = 3'b101,
    OP_READ    = 3'b110,
    OP_ILLEGAL = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_SRC = 3'd1,
    ST_RD_DST = 3'd2,
    ST_WR_DST = 3'd3,
    ST_WR_SRC = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  localparam logic [2:0] FUN_LOAD = 3'b010;
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] FUN_DEC  = 3'b000;
  localparam logic [2:0] FUN_CLR  = 3'b011;

  // Active-low enable vector {RegSel, ScrSel}: index 0 (R1) is bit 7,
  // index 3 (R4) is bit 4, index 4 (S1) is bit 3, index 7 (S4) is bit 0.
  function automatic logic [7:0] index_to_enables(input logic [2:0] idx);
    logic [7:0] en;
    en = 8'hFF;
    en[3'd7 - idx] = 1'b0;
    return en;
  endfunction

  // FunSel used when writing the destination; plain transfers are loads of I.
  function automatic logic [2:0] fun_for_op(input op_e op);
    logic [2:0] fun;
    case (op)
      OP_INC:  fun = FUN_INC;
      OP_DEC:  fun = FUN_DEC;
      OP_CLR:  fun = FUN_CLR;
      default: fun = FUN_LOAD;
    endcase
    return fun;
  endfunction

endpackage

// File: rtl/rf_transfer_sequencer.sv
// Command-driven initiator for the 8-entry register file. One command is
// accepted per valid/ready handshake and sequenced as reads (captured into
// HoldA/HoldB) followed by single-cycle writes, ending in a Done response.
module rf_transfer_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [2:0]       CmdOp,
  input  logic [2:0]       CmdSrc,
  input  logic [2:0]       CmdDst,
  input  logic [WIDTH-1:0] CmdData,
  input  logic [WIDTH-1:0] RfOutA,
  output logic [WIDTH-1:0] RfI,
  output logic [2:0]       RfOutASel,
  output logic [2:0]       RfOutBSel,
  output logic [2:0]       RfFunSel,
  output logic [3:0]       RfRegSel,
  output logic [3:0]       RfScrSel,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Err
);
  import rf_pkg::*;

  state_e           state;
  state_e           next_state;
  op_e              op_q;
  logic [2:0]       src_q;
  logic [2:0]       dst_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] hold_a;
  logic [WIDTH-1:0] hold_b;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] src_value;
  logic             err_q;
  logic             accept;
  logic [7:0]       enables;

  assign CmdReady  = (state == ST_IDLE);
  assign accept    = CmdValid && CmdReady;
  assign Done      = (state == ST_RESP);
  assign Err       = Done && err_q;
  assign Result    = result_q;
  assign RfOutBSel = RfOutASel;
  assign RfRegSel  = enables[7:4];
  assign RfScrSel  = enables[3:0];

  // The source value is still on OutA when leaving RD_SRC directly to RESP.
  assign src_value = (state == ST_RD_SRC) ? RfOutA : hold_a;

  // State register; reset returns to IDLE, which also forces enables inactive.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state sequencing; IDLE decodes the live command, later states the latched op.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op_e'(CmdOp))
            OP_LOAD, OP_INC, OP_DEC, OP_CLR: next_state = ST_WR_DST;
            OP_MOVE, OP_SWAP, OP_READ:       next_state = ST_RD_SRC;
            default:                         next_state = ST_RESP;
          endcase
        end
      end
      ST_RD_SRC: begin
        case (op_q)
          OP_MOVE: next_state = ST_WR_DST;
          OP_SWAP: next_state = (src_q == dst_q) ? ST_RESP : ST_RD_DST;
          default: next_state = ST_RESP;
        endcase
      end
      ST_RD_DST: next_state = ST_WR_DST;
      ST_WR_DST: next_state = (op_q == OP_SWAP) ? ST_WR_SRC : ST_RESP;
      ST_WR_SRC: next_state = ST_RESP;
      ST_RESP:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Register file drive: reads select OutA, writes pull exactly one enable low.
  always_comb begin
    enables   = 8'hFF;
    RfFunSel  = FUN_LOAD;
    RfI       = '0;
    RfOutASel = 3'd0;
    case (state)
      ST_RD_SRC: RfOutASel = src_q;
      ST_RD_DST: RfOutASel = dst_q;
      ST_WR_DST: begin
        enables  = index_to_enables(dst_q);
        RfFunSel = fun_for_op(op_q);
        RfI      = (op_q == OP_MOVE || op_q == OP_SWAP) ? hold_a : data_q;
      end
      ST_WR_SRC: begin
        enables  = index_to_enables(src_q);
        RfFunSel = FUN_LOAD;
        RfI      = hold_b;
      end
      default: ;
    endcase
  end

  // Response value for the command currently finishing.
  always_comb begin
    result_next = '0;
    case (op_q)
      OP_LOAD:                   result_next = data_q;
      OP_MOVE, OP_SWAP, OP_READ: result_next = src_value;
      default:                   result_next = '0;
    endcase
  end

  // Command latch, read holding registers and the held response.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      op_q     <= OP_LOAD;
      src_q    <= 3'd0;
      dst_q    <= 3'd0;
      data_q   <= '0;
      hold_a   <= '0;
      hold_b   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= op_e'(CmdOp);
        src_q  <= CmdSrc;
        dst_q  <= CmdDst;
        data_q <= CmdData;
        err_q  <= (op_e'(CmdOp) == OP_ILLEGAL);
      end
      if (state == ST_RD_SRC) hold_a <= RfOutA;
      if (state == ST_RD_DST) hold_b <= RfOutA;
      if (next_state == ST_RESP && state != ST_IDLE && state != ST_RESP)
        result_q <= result_next;
    end
  end

endmodule

// File: tb/tb_rf_transfer_sequencer.sv
// Directed bench for rf_transfer_sequencer with a behavioural register file
// attached and a scoreboard of expected responses.
module tb_rf_transfer_sequencer;

  localparam logic [2:0] OP_LOAD = 3'b000, OP_MOVE = 3'b001, OP_SWAP = 3'b010,
                         OP_INC  = 3'b011, OP_DEC  = 3'b100, OP_CLR  = 3'b101,
                         OP_READ = 3'b110, OP_BAD  = 3'b111;
  localparam logic [2:0] F_LOAD = 3'b010, F_INC = 3'b001, F_DEC = 3'b000, F_CLR = 3'b011;

  typedef struct {
    logic [15:0] result;
    logic        err;
    int          latency;
    int          writes;
  } exp_t;

  logic        Clock, Reset, CmdValid, CmdReady, Done, Err;
  logic [2:0]  CmdOp, CmdSrc, CmdDst, RfOutASel, RfOutBSel, RfFunSel;
  logic [3:0]  RfRegSel, RfScrSel;
  logic [15:0] CmdData, RfOutA, RfI, Result;

  logic [15:0] rf [8] = '{default: 16'h0000};
  logic [15:0] expRf [8];
  logic [15:0] lastResult;
  exp_t        sb [$];
  int          checks = 0;
  int          passes = 0;

  rf_transfer_sequencer #(.WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdSrc(CmdSrc), .CmdDst(CmdDst), .CmdData(CmdData),
    .RfOutA(RfOutA), .RfI(RfI), .RfOutASel(RfOutASel), .RfOutBSel(RfOutBSel),
    .RfFunSel(RfFunSel), .RfRegSel(RfRegSel), .RfScrSel(RfScrSel),
    .Done(Done), .Result(Result), .Err(Err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  assign RfOutA = rf[RfOutASel];

  // Behavioural register file: any entry with its active-low enable low applies FunSel.
  always @(posedge Clock) begin
    for (int i = 0; i < 8; i++) begin
      if (!(i < 4 ? RfRegSel[3 - i] : RfScrSel[7 - i])) begin
        case (RfFunSel)
          F_LOAD:  rf[i] <= RfI;
          F_INC:   rf[i] <= rf[i] + 16'd1;
          F_DEC:   rf[i] <= rf[i] - 16'd1;
          F_CLR:   rf[i] <= 16'h0000;
          default: ;
        endcase
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  // Reference behaviour of one command: updates the expected file and returns the response.
  task automatic buildExpect(input logic [2:0] op, input logic [2:0] src,
                             input logic [2:0] dst, input logic [15:0] data,
                             output exp_t e);
    logic [15:0] tmp;
    e.err = 1'b0;
    e.writes = 0;
    e.result = 16'h0000;
    e.latency = 2;
    case (op)
      OP_LOAD: begin e.result = data; expRf[dst] = data; e.writes = 1; end
      OP_MOVE: begin e.result = expRf[src]; expRf[dst] = expRf[src]; e.latency = 3; e.writes = 1; end
      OP_SWAP: begin
        e.result = expRf[src];
        if (src != dst) begin
          tmp = expRf[dst]; expRf[dst] = expRf[src]; expRf[src] = tmp;
          e.latency = 5; e.writes = 2;
        end
      end
      OP_INC:  begin expRf[dst] = expRf[dst] + 16'd1; e.writes = 1; end
      OP_DEC:  begin expRf[dst] = expRf[dst] - 16'd1; e.writes = 1; end
      OP_CLR:  begin expRf[dst] = 16'h0000; e.writes = 1; end
      OP_READ: e.result = expRf[src];
      default: begin e.result = lastResult; e.err = 1'b1; e.latency = 1; end
    endcase
    lastResult = e.result;
    sb.push_back(e);
  endtask

  // Called #1 after an accept edge: measures the command and compares against the scoreboard.
  task automatic waitDone();
    int cycles = 0, writes = 0, maxLow = 0, low, readyBusy = 0;
    logic seen = 1'b0;
    logic obsErr = 1'b0;
    logic [15:0] obsResult = 16'h0000;
    exp_t e;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge Clock);
      cycles++;
      low = $countones(~{RfRegSel, RfScrSel});
      if (low > 0) writes++;
      if (low > maxLow) maxLow = low;
      if (CmdReady === 1'b1) readyBusy++;
      if (Done === 1'b1) begin
        seen = 1'b1;
        obsErr = Err;
        obsResult = Result;
      end
    end
    checkOutput("doneSeen", {31'd0, seen}, 32'd1);
    if (sb.size() == 0) begin
      checkOutput("scoreboardEmpty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput("latency", cycles, e.latency);
      checkOutput("result", {16'd0, obsResult}, {16'd0, e.result});
      checkOutput("err", {31'd0, obsErr}, {31'd0, e.err});
      checkOutput("writeCycles", writes, e.writes);
      checkOutput("oneEnableAtATime", {31'd0, maxLow <= 1}, 32'd1);
      checkOutput("readyLowWhileBusy", readyBusy, 0);
      @(negedge Clock);
      checkOutput("donePulse", {31'd0, Done}, 32'd0);
      checkOutput("resultHeld", {16'd0, Result}, {16'd0, e.result});
      checkOutput("readyInIdle", {31'd0, CmdReady}, 32'd1);
    end
  endtask

  // Waits for ready, issues one command for a single handshake and checks its response.
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] src,
                               input logic [2:0] dst, input logic [15:0] data);
    exp_t e;
    int k = 0;
    @(negedge Clock);
    while (CmdReady !== 1'b1 && k < 20) begin @(negedge Clock); k++; end
    if (k >= 20) checkOutput("readyTimeout", 32'd0, 32'd1);
    buildExpect(op, src, dst, data, e);
    CmdValid = 1'b1; CmdOp = op; CmdSrc = src; CmdDst = dst; CmdData = data;
    @(posedge Clock);
    #1 CmdValid = 1'b0;
    waitDone();
  endtask

  task automatic checkReg(input string tag, input int idx);
    checkOutput(tag, {16'd0, rf[idx]}, {16'd0, expRf[idx]});
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 8; i++) expRf[i] = 16'h0000;
    lastResult = 16'h0000;
    Reset = 1'b0; CmdValid = 1'b0; CmdOp = 3'd0; CmdSrc = 3'd0; CmdDst = 3'd0; CmdData = 16'h0;
    repeat (2) @(negedge Clock);
    checkOutput("rstReady", {31'd0, CmdReady}, 32'd1);
    checkOutput("rstDone", {31'd0, Done}, 32'd0);
    checkOutput("rstErr", {31'd0, Err}, 32'd0);
    checkOutput("rstResult", {16'd0, Result}, 32'd0);
    checkOutput("rstRegSel", {28'd0, RfRegSel}, 32'hF);
    checkOutput("rstScrSel", {28'd0, RfScrSel}, 32'hF);
    checkOutput("rstFunSel", {29'd0, RfFunSel}, {29'd0, F_LOAD});
    checkOutput("rstRfI", {16'd0, RfI}, 32'd0);
    checkOutput("rstOutASel", {29'd0, RfOutASel}, 32'd0);
    checkOutput("rstOutBSel", {29'd0, RfOutBSel}, 32'd0);
    Reset = 1'b1;

    $display("[TB] load and read back");
    applyStimulus(OP_LOAD, 3'd0, 3'd2, 16'hBEEF);
    checkReg("loadR3", 2);
    applyStimulus(OP_READ, 3'd2, 3'd0, 16'h0);

    $display("[TB] swap R1 with S2");
    applyStimulus(OP_LOAD, 3'd0, 3'd0, 16'h1234);
    applyStimulus(OP_LOAD, 3'd0, 3'd5, 16'hABCD);
    applyStimulus(OP_SWAP, 3'd0, 3'd5, 16'h0);
    checkReg("swapR1", 0);
    checkReg("swapS2", 5);

    $display("[TB] inc/dec wrap");
    applyStimulus(OP_LOAD, 3'd0, 3'd3, 16'hFFFF);
    applyStimulus(OP_INC, 3'd0, 3'd3, 16'h0);
    checkReg("incWrapR4", 3);
    applyStimulus(OP_DEC, 3'd0, 3'd3, 16'h0);
    checkReg("decWrapR4", 3);

    $display("[TB] move, clear, self swap, illegal");
    applyStimulus(OP_MOVE, 3'd5, 3'd6, 16'h0);
    checkReg("moveS3", 6);
    applyStimulus(OP_CLR, 3'd0, 3'd0, 16'h0);
    checkReg("clrR1", 0);
    applyStimulus(OP_SWAP, 3'd2, 3'd2, 16'h0);
    checkReg("selfSwapR3", 2);
    applyStimulus(OP_BAD, 3'd1, 3'd4, 16'h5555);

    $display("[TB] valid held during swap");
    applyStimulus(OP_LOAD, 3'd0, 3'd1, 16'h5A5A);
    applyStimulus(OP_LOAD, 3'd0, 3'd4, 16'hC3C3);
    @(negedge Clock);
    buildExpect(OP_SWAP, 3'd1, 3'd4, 16'h0, e);
    buildExpect(OP_READ, 3'd4, 3'd0, 16'h0, e);
    CmdValid = 1'b1; CmdOp = OP_SWAP; CmdSrc = 3'd1; CmdDst = 3'd4; CmdData = 16'h0;
    @(posedge Clock);
    #1 CmdOp = OP_READ; CmdSrc = 3'd4; CmdDst = 3'd0;
    waitDone();
    @(posedge Clock);
    #1 checkOutput("heldCmdAccepted", {31'd0, CmdReady}, 32'd0);
    CmdValid = 1'b0;
    waitDone();
    checkReg("heldSwapR2", 1);
    checkReg("heldSwapS1", 4);

    $display("[TB] reset during move write");
    applyStimulus(OP_LOAD, 3'd0, 3'd1, 16'h1111);
    @(negedge Clock);
    CmdValid = 1'b1; CmdOp = OP_MOVE; CmdSrc = 3'd0; CmdDst = 3'd1; CmdData = 16'h0;
    @(posedge Clock);
    #1 CmdValid = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    checkOutput("wrDstEnable", {28'd0, RfRegSel}, 32'hB);
    Reset = 1'b0;
    #1;
    checkOutput("asyncRegSel", {28'd0, RfRegSel}, 32'hF);
    checkOutput("asyncScrSel", {28'd0, RfScrSel}, 32'hF);
    @(negedge Clock);
    Reset = 1'b1;
    lastResult = 16'h0000;
    @(negedge Clock);
    checkReg("moveAbandoned", 1);
    checkOutput("postRstReady", {31'd0, CmdReady}, 32'd1);
    checkOutput("postRstResult", {16'd0, Result}, 32'd0);
    applyStimulus(OP_READ, 3'd1, 3'd0, 16'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
